cntr_mod: RTL and testbench
===========================

# cntr_mod

Parametrised modulo counter: the next generation of the team's 4-bit `cntr`. It adds configurable width and terminal value, up/down direction, synchronous load, and three end-of-range modes (wrap, saturate, one-shot). It also adds terminal-count, sticky-overflow and done flags. It sits anywhere the design needs an event counter or timer; stepping is enabled by `c` and clocked by `pulse`, as in `cntr`.

## Interface
- `WIDTH`, 4: counter width in bits, ≥1.
- `MAX`, 2**WIDTH-1: terminal (highest) count value; count range is 0..MAX; requires 0 < MAX ≤ 2**WIDTH-1.
- `INIT`, 0: value of `o` after reset; requires INIT ≤ MAX.

- `pulse`  in  1  clock, rising edge active.
- `rst`  in  1  reset, asynchronous, active-high.
- `c`  in  1  count enable; one step per rising `pulse` while high.
- `up`  in  1  direction: 1 increments, 0 decrements.
- `ld`  in  1  synchronous load of `d`.
- `d`  in  WIDTH  load value.
- `mode`  in  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = reserved (behaves as wrap).
- `clr_ovf`  in  1  synchronous clear of `ovf`.
- `o`  out  WIDTH  current count.
- `tc`  out  1  terminal count: `o`==MAX when `up`=1, `o`==0 when `up`=0.
- `ovf`  out  1  sticky over/underflow flag.
- `done`  out  1  one-shot completed.

## Operation
- Reset (`rst`=1): `o`=INIT, `ovf`=0, `done`=0, immediately and independent of `pulse`. `tc` then follows from INIT and `up`.
- Priority per rising edge: `rst` > `ld` > count step > hold.
- Load: `o` ← `d`, clamped to MAX when `d`>MAX. `done` ← 0. `ovf` is not set by a load.
- Count step, taken when `c`=1, `ld`=0 and `done`=0:
  - Not at boundary: `o` ← `o`±1.
  - At boundary (`tc`=1):
    - wrap: `o` ← 0 (up) or MAX (down); `ovf` ← 1.
    - saturate: `o` holds; `ovf` ← 1.
    - one-shot: `o` holds; `done` ← 1; `ovf` unchanged.
- One-shot with `done`=1:
  - Counter is frozen until `ld` or `rst`.
  - A `c`=1 edge while frozen sets `ovf` ← 1.
- `clr_ovf`=1 clears `ovf`. When a set and a clear coincide on the same edge, set wins and `ovf` ends at 1.
- `mode` or `up` changes take effect on the next edge; no state is flushed.
- Arithmetic is modulo MAX+1 in wrap mode. Intermediate results never exceed WIDTH bits; the boundary compare is done before the ±1.

## Timing
- `o`, `ovf`, `done`: registered, updated on rising `pulse`; 1-cycle latency from `c`/`ld`.
- `tc`: combinational from `o` and `up`; valid in the same cycle as `o`.
- Reset assert: asynchronous. Reset deassert: counting resumes on the first rising `pulse` with `rst`=0.
- Reset mid-count or mid-load: the reset value wins and the load is lost.

## Structure
- Shared package `cntr_pkg`:
  - mode constants `MODE_WRAP`=0, `MODE_SAT`=1, `MODE_ONESHOT`=2.
  - mode type, 2 bits.
- One sub-module, `incdec`: the generalised `incr`.
  - Parameters WIDTH, MAX.
  - Inputs: `i`, `up`.
  - Outputs: `o` = next value with modulo wrap, and `edge` = `i` at boundary for the current direction.
  - Purely combinational.
- `cntr_mod` holds the registers and the mode/priority logic.

## Test plan
1. WIDTH=4, MAX=9, wrap, `up`=1, `c`=1, 12 edges from reset → `o`: 1..9, 0, 1, 2. `tc` high while `o`=9. `ovf`=1 after the 10th edge.
2. Saturate, `up`=0, start from reset (`o`=0), 3 edges with `c`=1 → `o` stays 0, `tc`=1, `ovf`=1 after the first edge; `clr_ovf` with `c`=0 → `ovf`=0.
3. One-shot, `ld` with `d`=7, then `up`=1, `c`=1 → `o` reaches 9 after 2 edges. On the 3rd edge `done`=1 and `o`=9. On the 4th edge `ovf`=1. Then `ld` with `d`=0 → `done`=0, `o`=0.
4. `ld`=1 and `c`=1 on the same edge with `d`=12 (MAX=9) → `o`=9 (clamped), no step, `ovf` unchanged.
5. Wrap at 9 with `c`=1 and `clr_ovf`=1 on the same edge → `o`=0, `ovf`=1 (set wins).
6. Assert `rst` between edges while `o`=5 → `o`=INIT immediately, `ovf`=0, `done`=0; counting resumes from INIT on the next edge after release.

Source files
------------

// File: rtl/cntr_pkg.sv
// Shared definitions for the cntr_mod modulo counter family.
// Holds the end-of-range mode encoding used by cntr_mod and its bench.
package cntr_pkg;

  // End-of-range behaviour; the fourth encoding is reserved and acts as wrap.
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_WRAP    = 2'd0;
  localparam mode_t MODE_SAT     = 2'd1;
  localparam mode_t MODE_ONESHOT = 2'd2;

endpackage : cntr_pkg

// File: rtl/cntr_mod_incdec.sv
// incdec: combinational +/-1 stage of a modulo (MAX+1) counter.
// Ports:
//   i        in  WIDTH  current value (assumed 0..MAX)
//   up       in  1      1 = increment, 0 = decrement
//   o        out WIDTH  next value, wrapping 0<->MAX
//   at_edge  out 1      i sits on the boundary for the current direction
//                       (named at_edge because `edge` is a reserved word)
module incdec #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = (1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0] i,
  input  logic             up,
  output logic [WIDTH-1:0] o,
  output logic             at_edge
);

  localparam logic [WIDTH-1:0] MAX_V  = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

  // The boundary compare happens before the +/-1, so the sum never
  // needs more than WIDTH bits.
  always_comb begin
    at_edge = 1'b0;
    o       = i;
    if (up) begin
      at_edge = (i == MAX_V);
      o       = at_edge ? ZERO_V : (i + ONE_V);
    end else begin
      at_edge = (i == ZERO_V);
      o       = at_edge ? MAX_V : (i - ONE_V);
    end
  end

endmodule : incdec

// File: rtl/cntr_mod.sv
// cntr_mod: parametrised up/down modulo counter with load, three
// end-of-range modes, terminal-count, sticky overflow and one-shot done.
// Ports:
//   pulse    in  1      clock, rising edge
//   rst      in  1      asynchronous active-high reset
//   c        in  1      count enable
//   up       in  1      1 = count up, 0 = count down
//   ld       in  1      synchronous load of d (clamped to MAX)
//   d        in  WIDTH  load value
//   mode     in  2      wrap / saturate / one-shot / reserved(=wrap)
//   clr_ovf  in  1      synchronous clear of ovf (a same-edge set wins)
//   o        out WIDTH  current count
//   tc       out 1      o at the boundary for the current direction
//   ovf      out 1      sticky over/underflow flag
//   done     out 1      one-shot has completed; counter frozen
module cntr_mod
  import cntr_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = (1 << WIDTH) - 1,
  parameter int unsigned INIT  = 0
) (
  input  logic             pulse,
  input  logic             rst,
  input  logic             c,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] o,
  output logic             tc,
  output logic             ovf,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V  = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_V = INIT[WIDTH-1:0];

  logic [WIDTH-1:0] step_val;
  logic             at_edge;
  logic [WIDTH-1:0] o_nxt;
  logic             ovf_set;
  logic             done_nxt;
  mode_t            mode_q;

  assign mode_q = mode_t'(mode);

  incdec #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_incdec (
    .i       (o),
    .up      (up),
    .o       (step_val),
    .at_edge (at_edge)
  );

  assign tc = at_edge;

  // Priority: load > count step > hold. A set of ovf from this edge
  // overrides clr_ovf, which is resolved in the register block.
  always_comb begin
    o_nxt    = o;
    ovf_set  = 1'b0;
    done_nxt = done;
    if (ld) begin
      o_nxt    = (d > MAX_V) ? MAX_V : d;
      done_nxt = 1'b0;
    end else if (c) begin
      if (done) begin
        // Frozen after a one-shot: further enables only flag overflow.
        ovf_set = 1'b1;
      end else if (!at_edge) begin
        o_nxt = step_val;
      end else begin
        case (mode_q)
          MODE_SAT: begin
            ovf_set = 1'b1;
          end
          MODE_ONESHOT: begin
            done_nxt = 1'b1;
          end
          default: begin
            o_nxt   = step_val;
            ovf_set = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge pulse or posedge rst) begin
    if (rst) begin
      o    <= INIT_V;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      o    <= o_nxt;
      done <= done_nxt;
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule : cntr_mod

// File: tb/tb_cntr_mod.sv
// Bench for cntr_mod with WIDTH=4, MAX=9, INIT=0.
module tb_cntr_mod;
  import cntr_pkg::*;

  localparam int W = 4;

  logic         pulse;
  logic         rst;
  logic         c;
  logic         up;
  logic         ld;
  logic [W-1:0] d;
  logic [1:0]   mode;
  logic         clr_ovf;
  logic [W-1:0] o;
  logic         tc;
  logic         ovf;
  logic         done;

  int errors;
  int checks;

  // Expected outputs packed as {o, tc, ovf, done}.
  logic [W+2:0] exp_q[$];

  typedef struct {
    logic         c;
    logic         up;
    logic         ld;
    logic [W-1:0] d;
    logic [1:0]   mode;
    logic         clr;
    logic [W-1:0] eo;
    logic         etc;
    logic         eovf;
    logic         edone;
    string        name;
  } vec_t;

  vec_t vecs[$];

  cntr_mod #(
    .WIDTH (W),
    .MAX   (9),
    .INIT  (0)
  ) dut (
    .pulse   (pulse),
    .rst     (rst),
    .c       (c),
    .up      (up),
    .ld      (ld),
    .d       (d),
    .mode    (mode),
    .clr_ovf (clr_ovf),
    .o       (o),
    .tc      (tc),
    .ovf     (ovf),
    .done    (done)
  );

  // Clock / reset
  initial begin
    pulse = 1'b0;
    forever #5 pulse = ~pulse;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic vc, input logic vup, input logic vld,
                              input int vd, input logic [1:0] vmode, input logic vclr,
                              input int eo, input logic etc, input logic eovf,
                              input logic edone, input string name);
    vec_t v;
    v.c = vc; v.up = vup; v.ld = vld; v.d = W'(vd); v.mode = vmode; v.clr = vclr;
    v.eo = W'(eo); v.etc = etc; v.eovf = eovf; v.edone = edone; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [W+2:0] act, input logic [W+2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got o=%0d tc=%b ovf=%b done=%b, want o=%0d tc=%b ovf=%b done=%b",
               name, act[W+2:3], act[2], act[1], act[0], exp[W+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Driver: present one vector, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    logic [W+2:0] exp;
    c = v.c; up = v.up; ld = v.ld; d = v.d; mode = v.mode; clr_ovf = v.clr;
    exp_q.push_back({v.eo, v.etc, v.eovf, v.edone});
    @(posedge pulse);
    #1;
    exp = exp_q.pop_front();
    check(v.name, {o, tc, ovf, done}, exp);
  endtask

  task automatic idle_inputs();
    c = 1'b0; ld = 1'b0; d = '0; clr_ovf = 1'b0; mode = MODE_WRAP; up = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Wrap, counting up from reset: 1..9, 0, 1, 2.
    for (int k = 1; k <= 12; k++)
      vecs.push_back(mk(1, 1, 0, 0, MODE_WRAP, 0, k % 10, (k == 9), (k >= 10), 0,
                        $sformatf("wrap_up_%0d", k)));
    vecs.push_back(mk(0, 1, 0, 0, MODE_WRAP, 1, 2, 0, 0, 0, "clr_ovf_hold"));
    vecs.push_back(mk(0, 1, 1, 9, MODE_WRAP, 0, 9, 1, 0, 0, "load_9"));
    vecs.push_back(mk(1, 1, 0, 0, MODE_WRAP, 1, 0, 0, 1, 0, "wrap_set_beats_clr"));
    vecs.push_back(mk(1, 1, 1, 12, MODE_WRAP, 0, 9, 1, 1, 0, "load_clamp_no_step"));
    vecs.push_back(mk(0, 1, 0, 0, MODE_WRAP, 1, 9, 1, 0, 0, "clr_after_clamp"));
    // Saturate, counting down from 0.
    vecs.push_back(mk(0, 0, 1, 0, MODE_SAT, 0, 0, 1, 0, 0, "load_0_down"));
    for (int k = 1; k <= 3; k++)
      vecs.push_back(mk(1, 0, 0, 0, MODE_SAT, 0, 0, 1, 1, 0, $sformatf("sat_down_%0d", k)));
    vecs.push_back(mk(0, 0, 0, 0, MODE_SAT, 1, 0, 1, 0, 0, "sat_clr"));
    // Saturate, counting up to MAX.
    vecs.push_back(mk(0, 1, 1, 8, MODE_SAT, 0, 8, 0, 0, 0, "load_8"));
    vecs.push_back(mk(1, 1, 0, 0, MODE_SAT, 0, 9, 1, 0, 0, "sat_up_reach"));
    vecs.push_back(mk(1, 1, 0, 0, MODE_SAT, 0, 9, 1, 1, 0, "sat_up_hold"));
    vecs.push_back(mk(0, 1, 0, 0, MODE_SAT, 1, 9, 1, 0, 0, "sat_up_clr"));
    // One-shot.
    vecs.push_back(mk(0, 1, 1, 7, MODE_ONESHOT, 0, 7, 0, 0, 0, "os_load_7"));
    vecs.push_back(mk(1, 1, 0, 0, MODE_ONESHOT, 0, 8, 0, 0, 0, "os_step_1"));
    vecs.push_back(mk(1, 1, 0, 0, MODE_ONESHOT, 0, 9, 1, 0, 0, "os_step_2"));
    vecs.push_back(mk(1, 1, 0, 0, MODE_ONESHOT, 0, 9, 1, 0, 1, "os_done"));
    vecs.push_back(mk(1, 1, 0, 0, MODE_ONESHOT, 0, 9, 1, 1, 1, "os_frozen_ovf"));
    vecs.push_back(mk(1, 1, 0, 0, MODE_ONESHOT, 1, 9, 1, 1, 1, "os_frozen_set_beats_clr"));
    vecs.push_back(mk(0, 1, 0, 0, MODE_WRAP, 0, 9, 1, 1, 1, "os_frozen_hold"));
    vecs.push_back(mk(0, 1, 1, 0, MODE_ONESHOT, 1, 0, 0, 0, 0, "os_reload_0"));
    // Wrap, counting down through 0.
    vecs.push_back(mk(0, 0, 1, 1, MODE_WRAP, 0, 1, 0, 0, 0, "load_1_down"));
    vecs.push_back(mk(1, 0, 0, 0, MODE_WRAP, 0, 0, 1, 0, 0, "wrap_down_to_0"));
    vecs.push_back(mk(1, 0, 0, 0, MODE_WRAP, 0, 9, 0, 1, 0, "wrap_down_to_max"));
    vecs.push_back(mk(1, 0, 0, 0, MODE_WRAP, 0, 8, 0, 1, 0, "wrap_down_8"));
    vecs.push_back(mk(0, 0, 0, 0, MODE_WRAP, 1, 8, 0, 0, 0, "wrap_down_clr"));
    // Reserved mode behaves as wrap.
    vecs.push_back(mk(0, 1, 1, 9, 2'd3, 0, 9, 1, 0, 0, "rsvd_load_9"));
    vecs.push_back(mk(1, 1, 0, 0, 2'd3, 0, 0, 0, 1, 0, "rsvd_wraps"));
    vecs.push_back(mk(0, 1, 0, 0, 2'd3, 0, 0, 0, 1, 0, "rsvd_hold"));
    vecs.push_back(mk(0, 1, 1, 5, MODE_WRAP, 0, 5, 0, 1, 0, "load_5_keeps_ovf"));

    // Reset state, before the first edge.
    rst = 1'b1;
    idle_inputs();
    #2;
    check("reset_up", {o, tc, ovf, done}, {4'd0, 1'b0, 1'b0, 1'b0});
    up = 1'b0;
    #1;
    check("reset_tc_down", {o, tc, ovf, done}, {4'd0, 1'b1, 1'b0, 1'b0});
    up = 1'b1;
    @(negedge pulse);
    rst = 1'b0;

    foreach (vecs[k]) apply(vecs[k]);

    // Asynchronous reset between edges with o=5 and a pending load.
    idle_inputs();
    ld = 1'b1;
    d  = 4'd3;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {o, tc, ovf, done}, {4'd0, 1'b0, 1'b0, 1'b0});
    @(posedge pulse);
    #1;
    check("reset_beats_load", {o, tc, ovf, done}, {4'd0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    ld  = 1'b0;
    c   = 1'b1;
    @(posedge pulse);
    #1;
    check("resume_after_reset", {o, tc, ovf, done}, {4'd1, 1'b0, 1'b0, 1'b0});

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cntr_mod
